pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter BR_PENALTY, default 2, the number of cycles FD_FLUSH stays asserted after a taken branch (range 1-3).
REQ-002 SHALL have parameter MAX_WAIT, default 15, the number of consecutive DMEM_BUSY cycles after which TIMEOUT sets.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port LOAD_USE  input  1  decode instruction sources the destination of a load in execute.
REQ-006 SHALL have port BR_TAKEN  input  1  execute resolved a taken branch or jump this cycle.
REQ-007 SHALL have port DMEM_BUSY  input  1  data memory not ready; the whole pipe must hold.
REQ-008 SHALL have ports PC_EN, FD_EN, DE_EN, EM_EN, MW_EN  output  1 each  pipeline register load enables.
REQ-009 SHALL have ports FD_FLUSH, DE_FLUSH  output  1 each  load a NOP bubble into the F/D or D/E register.
REQ-010 SHALL have port STALL_CNT  output  16  saturating count of cycles with PC_EN=0.
REQ-011 SHALL have port TIMEOUT  output  1  sticky flag set when memory wait exceeds MAX_WAIT.

Function
REQ-012 SHALL implement states RUN, LU_STALL, BR_FLUSH, MEM_WAIT.
REQ-013 SHALL prioritise DMEM_BUSY > BR_TAKEN > LOAD_USE when more than one input is high in the same cycle.
REQ-014 SHALL, in any state, drive all *_EN=0 and both flushes=0 combinationally in a cycle with DMEM_BUSY=1, then enter MEM_WAIT.
REQ-015 SHALL, in MEM_WAIT, hold the state that was active on entry (including the remaining flush count) and return to it on the first cycle with DMEM_BUSY=0.
REQ-016 SHALL, on BR_TAKEN with DMEM_BUSY=0, drive all enables=1, FD_FLUSH=1, DE_FLUSH=1 that cycle, and load the flush counter with BR_PENALTY-1.
REQ-017 SHALL, in BR_FLUSH, assert FD_FLUSH=1 with all enables=1 and decrement the counter each unfrozen cycle, returning to RUN after it reaches 0.
REQ-018 SHALL ignore LOAD_USE in the BR_TAKEN cycle and in BR_FLUSH, because the dependent instruction is flushed.
REQ-019 SHALL, on LOAD_USE in RUN with no higher-priority input, drive PC_EN=0, FD_EN=0, DE_FLUSH=1, and DE_EN=EM_EN=MW_EN=1 for exactly one cycle, then enter LU_STALL.
REQ-020 SHALL ignore LOAD_USE in LU_STALL, return to RUN on the next cycle, and drive all enables=1 and no flush in LU_STALL; the stall is at most one cycle per instruction.
REQ-021 SHALL increment STALL_CNT in every cycle with PC_EN=0 and saturate it at 16'hFFFF.
REQ-022 SHALL count consecutive DMEM_BUSY cycles, set TIMEOUT on count MAX_WAIT+1, and clear the wait count when DMEM_BUSY falls; TIMEOUT stays set until reset.
REQ-023 SHALL, in RUN with all inputs low, drive all enables=1 and both flushes=0.

Reset
REQ-024 SHALL, while RST_N=0, force state RUN, flush counter 0, wait counter 0, STALL_CNT=0, TIMEOUT=0.
REQ-025 SHALL, while RST_N=0, drive all *_EN=0 and FD_FLUSH=DE_FLUSH=1.
REQ-026 SHALL abandon any in-progress stall, flush or wait when RST_N asserts, with no residual effect after release.

Structure
REQ-027 SHALL place the state enum, the BR_PENALTY default and the MAX_WAIT default in shared package pipe_ctrl_pkg.
REQ-028 SHALL use sub-module sat_counter (parameterised width, inc, clr, saturate) for both STALL_CNT and the wait counter.

Verification
REQ-029 SHALL cover: LOAD_USE=1 for 2 cycles from RUN -> PC_EN=0 and DE_FLUSH=1 in cycle 1 only, PC_EN=1 in cycle 2, STALL_CNT=1.
REQ-030 SHALL cover: BR_TAKEN=1 for one cycle with BR_PENALTY=2 -> DE_FLUSH=1 for 1 cycle, FD_FLUSH=1 for 2 cycles, then RUN.
REQ-031 SHALL cover: BR_TAKEN and LOAD_USE in the same cycle -> branch flush only, PC_EN stays 1, STALL_CNT unchanged.
REQ-032 SHALL cover: DMEM_BUSY for 3 cycles in the second BR_FLUSH cycle -> all enables=0 for 3 cycles, then FD_FLUSH=1 for the single remaining cycle.
REQ-033 SHALL cover: DMEM_BUSY held 16 cycles with MAX_WAIT=15 -> TIMEOUT=1 on cycle 16 and stays 1 after busy drops.
REQ-034 SHALL cover: RST_N pulsed low mid-LU_STALL -> outputs take their reset values immediately, and RUN with all enables=1 follows the first edge after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and parameter defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    BR_FLUSH,
    MEM_WAIT
  } pipe_state_t;

  localparam int unsigned BR_PENALTY_DEF = 2;
  localparam int unsigned MAX_WAIT_DEF   = 15;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze,
// plus stall statistics and a sticky memory-timeout flag.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BR_PENALTY = BR_PENALTY_DEF,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD_USE,
  input  logic        BR_TAKEN,
  input  logic        DMEM_BUSY,
  output logic        PC_EN,
  output logic        FD_EN,
  output logic        DE_EN,
  output logic        EM_EN,
  output logic        MW_EN,
  output logic        FD_FLUSH,
  output logic        DE_FLUSH,
  output logic [15:0] STALL_CNT,
  output logic        TIMEOUT
);

  localparam int unsigned WAIT_W     = $clog2(MAX_WAIT + 2);
  localparam logic [1:0]  FLUSH_INIT = 2'(BR_PENALTY - 1);

  pipe_state_t       state_q, state_d, ret_q, ret_d, eff_state;
  logic [1:0]        flush_q, flush_d;
  logic [WAIT_W-1:0] wait_cnt;

  // MEM_WAIT is transparent: once busy drops, the held state acts in that same cycle.
  always_comb begin
    eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
    state_d   = state_q;
    ret_d     = ret_q;
    flush_d   = flush_q;
    {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN} = '0;
    FD_FLUSH  = 1'b0;
    DE_FLUSH  = 1'b0;
    if (!RST_N) begin
      FD_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end else if (DMEM_BUSY) begin
      state_d = MEM_WAIT;
      ret_d   = eff_state;
    end else begin
      {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN} = '1;
      state_d = RUN;
      if (BR_TAKEN) begin
        FD_FLUSH = 1'b1;
        DE_FLUSH = 1'b1;
        flush_d  = FLUSH_INIT;
        state_d  = (FLUSH_INIT == 2'd0) ? RUN : BR_FLUSH;
      end else begin
        case (eff_state)
          BR_FLUSH: begin
            FD_FLUSH = 1'b1;
            flush_d  = flush_q - 2'd1;
            if (flush_q > 2'd1) state_d = BR_FLUSH;
          end
          LU_STALL: state_d = RUN;
          default: begin
            if (LOAD_USE) begin
              PC_EN    = 1'b0;
              FD_EN    = 1'b0;
              DE_FLUSH = 1'b1;
              state_d  = LU_STALL;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      ret_q   <= RUN;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      flush_q <= flush_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (1'b0),
    .inc   (~PC_EN),
    .count (STALL_CNT)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (~DMEM_BUSY),
    .inc   (DMEM_BUSY),
    .count (wait_cnt)
  );

  // Sets on the edge where the consecutive-busy count reaches MAX_WAIT+1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TIMEOUT <= 1'b0;
    end else if (DMEM_BUSY && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
      TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random stimulus for pipe_ctrl checked against a cycle-level hazard model.
module tb_pipe_ctrl;

  localparam int unsigned BRP = 2;
  localparam int unsigned MWT = 15;

  logic        CLK = 1'b0;
  logic        RST_N, LOAD_USE, BR_TAKEN, DMEM_BUSY;
  logic        PC_EN, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH, TIMEOUT;
  logic [15:0] STALL_CNT;

  pipe_ctrl #(.BR_PENALTY(BRP), .MAX_WAIT(MWT)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .LOAD_USE  (LOAD_USE),
    .BR_TAKEN  (BR_TAKEN),
    .DMEM_BUSY (DMEM_BUSY),
    .PC_EN     (PC_EN),
    .FD_EN     (FD_EN),
    .DE_EN     (DE_EN),
    .EM_EN     (EM_EN),
    .MW_EN     (MW_EN),
    .FD_FLUSH  (FD_FLUSH),
    .DE_FLUSH  (DE_FLUSH),
    .STALL_CNT (STALL_CNT),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Model: owed FD-only flush cycles, whether the last unfrozen cycle was a load-use stall,
  // consecutive busy cycles, stall statistics and the sticky timeout.
  int m_flush_left, m_wait, m_stall_cnt;
  bit m_stalled, m_timeout;

  // Control vector order: {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH}
  localparam logic [6:0] V_RESET = 7'b00000_11;
  localparam logic [6:0] V_FREEZE = 7'b00000_00;
  localparam logic [6:0] V_RUN   = 7'b11111_00;
  localparam logic [6:0] V_BR    = 7'b11111_11;
  localparam logic [6:0] V_FLUSH = 7'b11111_10;
  localparam logic [6:0] V_LU    = 7'b00111_01;

  function automatic void model_reset();
    m_flush_left = 0;
    m_wait       = 0;
    m_stall_cnt  = 0;
    m_stalled    = 1'b0;
    m_timeout    = 1'b0;
  endfunction

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {PC_EN, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s ctl: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    vectors++;
    assert (STALL_CNT === 16'(m_stall_cnt)) else begin
      miscompares++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, STALL_CNT, m_stall_cnt);
    end
    vectors++;
    assert (TIMEOUT === m_timeout) else begin
      miscompares++;
      $error("FAIL %s timeout: observed %b expected %b", tag, TIMEOUT, m_timeout);
    end
  endtask

  // Called 1 time unit after a rising edge; checks outputs mid-cycle, then counters after the edge.
  task automatic step(input string tag, input bit lu, input bit br, input bit busy);
    logic [6:0] exp;
    LOAD_USE  = lu;
    BR_TAKEN  = br;
    DMEM_BUSY = busy;
    #2;
    if (busy) begin
      exp = V_FREEZE;
      if (m_stall_cnt < 65535) m_stall_cnt++;
      m_wait++;
      if (m_wait == MWT + 1) m_timeout = 1'b1;
    end else begin
      m_wait = 0;
      if (br) begin
        exp          = V_BR;
        m_flush_left = BRP - 1;
        m_stalled    = 1'b0;
      end else if (m_flush_left > 0) begin
        exp = V_FLUSH;
        m_flush_left--;
      end else if (m_stalled) begin
        exp       = V_RUN;
        m_stalled = 1'b0;
      end else if (lu) begin
        exp       = V_LU;
        m_stalled = 1'b1;
        if (m_stall_cnt < 65535) m_stall_cnt++;
      end else begin
        exp = V_RUN;
      end
    end
    check_ctl(tag, exp);
    @(posedge CLK);
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    #1;
    check_ctl("reset", V_RESET);
    check_regs("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N     = 1'b0;
    LOAD_USE  = 1'b0;
    BR_TAKEN  = 1'b0;
    DMEM_BUSY = 1'b0;
    do_reset();

    step("idle", 0, 0, 0);

    // Load-use held two cycles: one-cycle stall only.
    step("lu_c1", 1, 0, 0);
    step("lu_c2", 1, 0, 0);
    step("lu_after", 0, 0, 0);

    // Taken branch with penalty 2.
    step("br_c1", 0, 1, 0);
    step("br_c2", 0, 0, 0);
    step("br_run", 0, 0, 0);

    // Branch and load-use together: branch wins, no stall.
    step("br_lu_c1", 1, 1, 0);
    step("br_lu_c2", 1, 0, 0);
    step("br_lu_c3", 0, 0, 0);

    // Memory busy during the remaining flush cycle.
    step("brw_c1", 0, 1, 0);
    for (int i = 0; i < 3; i++) step("brw_busy", 0, 0, 1);
    step("brw_flush", 0, 0, 0);
    step("brw_run", 0, 0, 0);

    // Busy during load-use stall, then resume the stall exit.
    step("luw_c1", 1, 0, 0);
    step("luw_busy", 1, 0, 1);
    step("luw_ret", 1, 0, 0);
    step("luw_run", 0, 0, 0);

    // Reset pulsed while in LU_STALL.
    step("rst_lu", 1, 0, 0);
    LOAD_USE = 1'b0;
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_ctl("rst_mid", V_RESET);
    check_regs("rst_mid");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step("rst_rel", 0, 0, 0);
    step("rst_rel2", 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0));
    end

    // Timeout on the 16th consecutive busy cycle, sticky afterwards.
    do_reset();
    for (int i = 0; i < 16; i++) step("tmo_busy", 0, 0, 1);
    step("tmo_drop", 0, 0, 0);
    step("tmo_hold", 1, 0, 0);
    step("tmo_hold2", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
